// File: rtl/stage_flow_if.sv
// Handshake bundle between the stage-flow sequencer and the game-flow datapath:
// feedback levels into the sequencer, Moore phase controls and status out of it.
interface stage_flow_if #(
   parameter int unsigned STAGE_W = 2,
   parameter int unsigned LIVES_W = 4
);
   logic               start;
   logic               restart;
   logic               start_display_done;
   logic               begin_done;
   logic               tower_done;
   logic               car_done;
   logic               end_display_done;
   logic               car_leak;
   logic               game_over_feedback;
   logic               skip;

   logic               wait_start;
   logic               stage_begin;
   logic               stage_draw_tower;
   logic               stage_in_progress;
   logic               stage_done;
   logic [STAGE_W-1:0] stage_idx;
   logic [LIVES_W-1:0] lives;
   logic               win;
   logic               game_over;
   logic               timeout_err;

   modport master (
      input  start, restart, start_display_done, begin_done, tower_done, car_done,
             end_display_done, car_leak, game_over_feedback, skip,
      output wait_start, stage_begin, stage_draw_tower, stage_in_progress, stage_done,
             stage_idx, lives, win, game_over, timeout_err
   );

   modport slave (
      output start, restart, start_display_done, begin_done, tower_done, car_done,
             end_display_done, car_leak, game_over_feedback, skip,
      input  wait_start, stage_begin, stage_draw_tower, stage_in_progress, stage_done,
             stage_idx, lives, win, game_over, timeout_err
   );
endinterface

// File: rtl/stage_flow_sequencer.sv
// Game-flow FSM sequencing NUM_STAGES stages with lives, per-phase watchdog and restart.
// Define STAGE_SKIP_EN to honour the debug skip input; otherwise skip is ignored.
module stage_flow_sequencer #(
   parameter int unsigned NUM_STAGES     = 3,
   parameter int unsigned STAGE_W        = 2,
   parameter int unsigned LIVES_W        = 4,
   parameter int unsigned INIT_LIVES     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TO_W           = 32
) (
   input logic         clk,
   input logic         reset,
   stage_flow_if.master bus
);

   localparam logic [2:0] S_WAIT       = 3'd0;
   localparam logic [2:0] S_BEGIN      = 3'd1;
   localparam logic [2:0] S_TOWER      = 3'd2;
   localparam logic [2:0] S_PLAY       = 3'd3;
   localparam logic [2:0] S_DONE       = 3'd4;
   localparam logic [2:0] S_WIN        = 3'd5;
   localparam logic [2:0] S_OVER       = 3'd6;
   localparam logic [2:0] S_OVER_SHOWN = 3'd7;

   localparam bit               WD_EN      = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0]  WD_LIMIT   = TO_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);

   logic [2:0]         state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               terr_q, terr_d;
   logic [TO_W-1:0]    wd_q, wd_d;

   logic fb;          // awaited feedback of a watchdog-guarded phase
   logic wd_active;
   logic wd_expire;
   logic leak_over;

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      lives_d   = lives_q;
      terr_d    = terr_q;
      fb        = 1'b0;
      wd_active = 1'b0;
      leak_over = 1'b0;

      unique case (state_q)
         S_WAIT: if (bus.start && bus.start_display_done) state_d = S_BEGIN;
         S_BEGIN: begin
            wd_active = 1'b1;
            fb        = bus.begin_done;
            if (fb) state_d = S_TOWER;
         end
         S_TOWER: begin
            wd_active = 1'b1;
            fb        = bus.tower_done;
            if (fb) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (bus.car_done) state_d = S_DONE;
            // Leak is applied before car_done; the last life forces game over.
            if (bus.car_leak) begin
               if (lives_q > LIVES_W'(1)) begin
                  lives_d = lives_q - LIVES_W'(1);
               end else begin
                  lives_d   = '0;
                  leak_over = 1'b1;
               end
            end
         end
         S_DONE: begin
            wd_active = 1'b1;
            fb        = bus.end_display_done;
            if (fb) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = S_WIN;
               end else begin
                  stage_d = stage_q + STAGE_W'(1);
                  state_d = S_BEGIN;
               end
            end
         end
         S_WIN, S_OVER_SHOWN: begin
            if (bus.restart) begin
               state_d = S_WAIT;
               stage_d = '0;
               lives_d = LIVES_INIT;
               terr_d  = 1'b0;
            end
         end
         S_OVER: if (bus.game_over_feedback) state_d = S_OVER_SHOWN;
         default: state_d = S_WAIT;
      endcase

`ifdef STAGE_SKIP_EN
      if (bus.skip && (state_q == S_BEGIN || state_q == S_TOWER || state_q == S_PLAY)) begin
         state_d = S_DONE;
      end
`endif

      wd_expire = WD_EN && wd_active && (wd_q == WD_LIMIT) && !fb;
      if (leak_over || wd_expire) state_d = S_OVER;
      if (wd_expire) terr_d = 1'b1;

      if (!WD_EN || state_d != state_q) begin
         wd_d = '0;
      end else if (wd_active) begin
         wd_d = wd_q + TO_W'(1);
      end else begin
         wd_d = wd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         stage_q <= '0;
         lives_q <= LIVES_INIT;
         terr_q  <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         lives_q <= lives_d;
         terr_q  <= terr_d;
         wd_q    <= wd_d;
      end
   end

   assign bus.wait_start        = (state_q == S_WAIT);
   assign bus.stage_begin       = (state_q == S_BEGIN);
   assign bus.stage_draw_tower  = (state_q == S_TOWER);
   assign bus.stage_in_progress = (state_q == S_PLAY);
   assign bus.stage_done        = (state_q == S_DONE);
   assign bus.win               = (state_q == S_WIN);
   assign bus.game_over         = (state_q == S_OVER) || (state_q == S_OVER_SHOWN);
   assign bus.stage_idx         = stage_q;
   assign bus.lives             = lives_q;
   assign bus.timeout_err       = terr_q;

endmodule

// File: tb/tb_stage_flow_sequencer.sv
// Directed bench for stage_flow_sequencer (3 stages, 5 lives, 10-cycle watchdog).
module tb_stage_flow_sequencer;

   localparam logic [6:0] PH_WAIT  = 7'b1000000;
   localparam logic [6:0] PH_BEGIN = 7'b0100000;
   localparam logic [6:0] PH_TOWER = 7'b0010000;
   localparam logic [6:0] PH_PLAY  = 7'b0001000;
   localparam logic [6:0] PH_DONE  = 7'b0000100;
   localparam logic [6:0] PH_WIN   = 7'b0000010;
   localparam logic [6:0] PH_OVER  = 7'b0000001;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   stage_flow_if #(.STAGE_W(2), .LIVES_W(4)) bus ();

   stage_flow_sequencer #(
      .NUM_STAGES    (3),
      .STAGE_W       (2),
      .LIVES_W       (4),
      .INIT_LIVES    (5),
      .TIMEOUT_CYCLES(10),
      .TO_W          (32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] phase();
      return {bus.wait_start, bus.stage_begin, bus.stage_draw_tower, bus.stage_in_progress,
              bus.stage_done, bus.win, bus.game_over};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [6:0] ph, input int idx, input int lv,
                          input logic te);
      chk({tag, ".phase"}, 32'(phase()), 32'(ph));
      chk({tag, ".idx"}, 32'(bus.stage_idx), 32'(idx));
      chk({tag, ".lives"}, 32'(bus.lives), 32'(lv));
      chk({tag, ".terr"}, 32'(bus.timeout_err), 32'(te));
   endtask

   // sel: 0 begin_done, 1 tower_done, 2 car_done, 3 end_display_done, 4 car_leak,
   //      5 game_over_feedback, 6 restart, 7 skip, 8 car_leak+car_done
   task automatic pulse(input int sel);
      case (sel)
         0: bus.begin_done = 1'b1;
         1: bus.tower_done = 1'b1;
         2: bus.car_done = 1'b1;
         3: bus.end_display_done = 1'b1;
         4: bus.car_leak = 1'b1;
         5: bus.game_over_feedback = 1'b1;
         6: bus.restart = 1'b1;
         7: bus.skip = 1'b1;
         default: begin bus.car_leak = 1'b1; bus.car_done = 1'b1; end
      endcase
      step();
      bus.begin_done = 1'b0; bus.tower_done = 1'b0; bus.car_done = 1'b0;
      bus.end_display_done = 1'b0; bus.car_leak = 1'b0; bus.game_over_feedback = 1'b0;
      bus.restart = 1'b0; bus.skip = 1'b0;
   endtask

   task automatic start_game();
      bus.start = 1'b1; bus.start_display_done = 1'b1;
      step();
      bus.start = 1'b0; bus.start_display_done = 1'b0;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.restart = 1'b0; bus.start_display_done = 1'b0;
      bus.begin_done = 1'b0; bus.tower_done = 1'b0; bus.car_done = 1'b0;
      bus.end_display_done = 1'b0; bus.car_leak = 1'b0; bus.game_over_feedback = 1'b0;
      bus.skip = 1'b0;
      step(); step();
      reset = 1'b0;
      chk_all("reset", PH_WAIT, 0, 5, 1'b0);

      // start alone is not enough
      bus.start = 1'b1; step(); bus.start = 1'b0;
      chk("start_only", 32'(phase()), 32'(PH_WAIT));

      // Nominal three-stage run
      start_game();
      chk_all("s0_begin", PH_BEGIN, 0, 5, 1'b0);
      for (int s = 0; s < 3; s++) begin
         pulse(0); chk("tower", 32'(phase()), 32'(PH_TOWER));
         if (s == 0) begin
            pulse(4); chk_all("leak_in_tower", PH_TOWER, 0, 5, 1'b0);
         end
         pulse(1); chk("play", 32'(phase()), 32'(PH_PLAY));
         pulse(2); chk_all("done", PH_DONE, s, 5, 1'b0);
         pulse(3);
         if (s < 2) chk_all("next_begin", PH_BEGIN, s + 1, 5, 1'b0);
         else chk_all("win", PH_WIN, 2, 5, 1'b0);
      end
      step(); chk("win_hold", 32'(phase()), 32'(PH_WIN));
      pulse(6); chk_all("restart_from_win", PH_WAIT, 0, 5, 1'b0);

      // Lives: two leaks, then simultaneous leak+done with lives 3 and with lives 1
      start_game(); pulse(0); pulse(1);
      pulse(4); chk_all("leak1", PH_PLAY, 0, 4, 1'b0);
      pulse(4); chk_all("leak2", PH_PLAY, 0, 3, 1'b0);
      pulse(8); chk_all("leak_done_l3", PH_DONE, 0, 2, 1'b0);
      pulse(3); pulse(0); pulse(1);
      chk_all("s1_play", PH_PLAY, 1, 2, 1'b0);
      pulse(4); chk_all("leak3", PH_PLAY, 1, 1, 1'b0);
      pulse(8); chk_all("leak_done_l1", PH_OVER, 1, 0, 1'b0);
      pulse(6); chk_all("restart_in_over", PH_OVER, 1, 0, 1'b0);
      pulse(5); chk_all("over_shown", PH_OVER, 1, 0, 1'b0);
      pulse(6); chk_all("restart_from_over", PH_WAIT, 0, 5, 1'b0);

      // Watchdog expiry in S_BEGIN: game over exactly 10 cycles after entry
      start_game();
      for (int i = 0; i < 9; i++) step();
      chk_all("wd_cycle9", PH_BEGIN, 0, 5, 1'b0);
      step();
      chk_all("wd_expired", PH_OVER, 0, 5, 1'b1);
      pulse(5); pulse(6);
      chk_all("wd_restart", PH_WAIT, 0, 5, 1'b0);

      // Feedback on the expiry cycle wins
      start_game();
      for (int i = 0; i < 9; i++) step();
      pulse(0); chk_all("wd_fb_wins", PH_TOWER, 0, 5, 1'b0);
      pulse(1);
      for (int i = 0; i < 20; i++) step();
      chk_all("play_exempt", PH_PLAY, 0, 5, 1'b0);

      // Reset in S_PLAY of stage 1
      pulse(2); pulse(3); pulse(0); pulse(1); pulse(4);
      chk_all("s1_play_b", PH_PLAY, 1, 4, 1'b0);
      reset = 1'b1; step(); reset = 1'b0;
      chk_all("mid_reset", PH_WAIT, 0, 5, 1'b0);

      // Debug skip in S_TOWER
      start_game(); pulse(0);
      pulse(7);
`ifdef STAGE_SKIP_EN
      chk_all("skip", PH_DONE, 0, 5, 1'b0);
`else
      chk_all("skip_ignored", PH_TOWER, 0, 5, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stage_flow_sequencer.md
Name: stage_flow_sequencer

Overview:
- Parametrised successor to the fixed three-stage game-flow control FSM.
- Sequences NUM_STAGES identical stages, each running begin → draw_tower → in_progress → done, through feedback handshakes with the game datapath.
- Adds a lives counter, a per-phase watchdog timeout, and a restart path.
- Sits between the game-flow datapath (feedback in, phase controls out) and the top level.

Parameters:
- NUM_STAGES, 3, number of stages played before win; minimum 1.
- STAGE_W, 2, width of stage_idx; must satisfy 2^STAGE_W >= NUM_STAGES.
- LIVES_W, 4, width of lives counter.
- INIT_LIVES, 5, lives loaded at reset and restart; 1..2^LIVES_W-1.
- TIMEOUT_CYCLES, 0, per-phase watchdog limit in clk cycles; 0 disables the watchdog.
- TO_W, 32, watchdog counter width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  leave wait_start (level, sampled)
- restart  in  1  from win/game_over, return to wait_start
- start_display_done  in  1  start screen drawn
- begin_done  in  1  stage begin screen drawn
- tower_done  in  1  tower placement finished
- car_done  in  1  all cars of the stage resolved
- end_display_done  in  1  stage end screen drawn
- car_leak  in  1  one-cycle pulse, a car reached the base
- game_over_feedback  in  1  game-over screen drawn
- skip  in  1  debug stage skip (only with STAGE_SKIP_EN)
- wait_start  out  1  state S_WAIT
- stage_begin  out  1  state S_BEGIN
- stage_draw_tower  out  1  state S_TOWER
- stage_in_progress  out  1  state S_PLAY
- stage_done  out  1  state S_DONE
- stage_idx  out  STAGE_W  current stage, 0-based
- lives  out  LIVES_W  remaining lives
- win  out  1  state S_WIN
- game_over  out  1  state S_OVER or S_OVER_SHOWN
- timeout_err  out  1  sticky; set when the watchdog caused game over

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On reset: state S_WAIT, wait_start=1, all other phase outputs 0, stage_idx=0, lives=INIT_LIVES, timeout_err=0, watchdog count 0.
- Outputs: all phase outputs are Moore, decoded from registered state. Exactly one of {wait_start, stage_begin, stage_draw_tower, stage_in_progress, stage_done, win, game_over} is high every cycle.
- Feedback inputs are levels. A transition occurs on the first rising clk edge where the input is sampled high, so the phase output changes 1 cycle after the feedback is asserted.
- Transitions:
  - S_WAIT → S_BEGIN when start && start_display_done.
  - S_BEGIN → S_TOWER on begin_done.
  - S_TOWER → S_PLAY on tower_done.
  - S_PLAY → S_DONE on car_done.
  - S_DONE on end_display_done: if stage_idx == NUM_STAGES-1 → S_WIN; else stage_idx+1 → S_BEGIN.
  - S_WIN → S_WAIT on restart.
  - S_OVER → S_OVER_SHOWN on game_over_feedback.
  - S_OVER_SHOWN → S_WAIT on restart.
  - Leaving via restart reloads lives, clears stage_idx and timeout_err.
- Lives:
  - car_leak is counted only in S_PLAY; ignored elsewhere.
  - Each counted car_leak decrements lives. A decrement when lives==1 sets lives=0 and goes to S_OVER.
  - lives never wraps below 0.
  - car_leak and car_done in the same cycle: the decrement applies first. If lives reach 0 → S_OVER, else → S_DONE.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on every state change. It increments in S_BEGIN, S_TOWER and S_DONE only; S_PLAY and S_WAIT are exempt.
  - When the count reaches TIMEOUT_CYCLES-1 without the awaited feedback → S_OVER and timeout_err=1.
  - If feedback and expiry occur in the same cycle, the feedback wins.
- Priority within a cycle: reset > game-over cause (lives or watchdog) > skip > normal feedback.
- Reset mid-operation: immediate return to reset values regardless of state; no pending feedback is remembered.

Optional Feature:
- Macro: STAGE_SKIP_EN
- Defined: skip sampled high in S_BEGIN, S_TOWER or S_PLAY forces S_DONE on the next cycle. stage_idx and lives are unchanged; the watchdog clears.
- Undefined: the skip port exists but is ignored; no logic is generated for it.

Test Plan:
- Nominal run, NUM_STAGES=3: reset, then start=1 and start_display_done=1. Pulse feedbacks in order for each stage → stage_idx steps 0,1,2; win=1 one cycle after the third end_display_done; lives stays 5.
- Lives exhaustion, INIT_LIVES=2: in stage 0 S_PLAY, pulse car_leak twice → lives 2→1→0; game_over=1 the cycle after the second pulse. car_leak in S_TOWER leaves lives unchanged.
- Simultaneous events: lives=1, car_leak and car_done in the same cycle → S_OVER, not S_DONE. With lives=3, same stimulus → S_DONE and lives=2.
- Watchdog, TIMEOUT_CYCLES=10: hold begin_done low in S_BEGIN → game_over and timeout_err=1 exactly 10 cycles after entering S_BEGIN. Asserting begin_done on cycle 10 → S_TOWER with timeout_err=0.
- Restart and reset: from S_WIN assert restart → wait_start=1, stage_idx=0, lives=5. Assert reset in S_PLAY of stage 1 → all outputs at reset values on the next cycle.
- STAGE_SKIP_EN defined: skip in S_TOWER of stage 0 → stage_done next cycle, stage_idx still 0. Macro undefined, same stimulus → stays in S_TOWER.
